// File: rtl/image_read_seq_if.sv
// Control handshake and RAM read bus of image_read_seq.
// master = sequencer side, slave = frame controller / pixel consumer side.
interface image_read_seq_if #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int CHANNELS = 3
);
    localparam int N  = ROWS * COLS * CHANNELS;
    localparam int AW = $clog2(N);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int KW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic          start;
    logic          mode;
    logic          stall;
    logic          data_done;
    logic          busy;
    logic          enable_a;
    logic [AW-1:0] addr;
    logic [AW-1:0] addr_dly;
    logic          valid_dly;
    logic [RW-1:0] row_dly;
    logic [CW-1:0] col_dly;
    logic [KW-1:0] cha_dly;
    logic          data_rdy;

    modport master (
        input  start, mode, stall, data_done,
        output busy, enable_a, addr, addr_dly, valid_dly,
               row_dly, col_dly, cha_dly, data_rdy
    );

    modport slave (
        output start, mode, stall, data_done,
        input  busy, enable_a, addr, addr_dly, valid_dly,
               row_dly, col_dly, cha_dly, data_rdy
    );
endinterface

// File: rtl/image_read_seq.sv
// Read-address sequencer for a ROWS x COLS x CHANNELS frame buffer with MEM_LAT read latency.
// Optional IMG_READ_SEQ_PERF_EN adds a saturating frame_cycles counter of READ+DRAIN cycles.
module image_read_seq #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int CHANNELS = 3,
    parameter int MEM_LAT  = 2
) (
    input  logic             clk,
    input  logic             reset,
    image_read_seq_if.master bus
`ifdef IMG_READ_SEQ_PERF_EN
    ,
    output logic [15:0]      frame_cycles
`endif
);
    localparam int N  = ROWS * COLS * CHANNELS;
    localparam int AW = $clog2(N);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int KW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, WAIT} state_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic [KW-1:0] cha;
    } stage_t;

    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt;
    logic [RW-1:0] row, row_nxt;
    logic [CW-1:0] col, col_nxt;
    logic [KW-1:0] cha, cha_nxt;
    logic          mode_q;
    logic          enable_c;
    logic          start_acc;
    logic          row_wrap, col_wrap, cha_wrap, last_coord;
    logic [AW-1:0] addr_c;
    stage_t        pipe [MEM_LAT];

    assign start_acc  = (state == IDLE) && bus.start && !bus.data_done;
    assign row_wrap   = (row == RW'(ROWS - 1));
    assign col_wrap   = (col == CW'(COLS - 1));
    assign cha_wrap   = (cha == KW'(CHANNELS - 1));
    assign last_coord = row_wrap && col_wrap && cha_wrap;
    assign addr_c     = AW'(cha) * AW'(ROWS * COLS) + AW'(row) * AW'(COLS) + AW'(col);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        enable_c  = 1'b0;
        case (state)
            IDLE:  if (start_acc) state_nxt = READ;
            READ: begin
                enable_c = !bus.stall;
                if (enable_c && last_coord) state_nxt = DRAIN;
            end
            DRAIN: if (drain_cnt == DW'(MEM_LAT - 1)) state_nxt = WAIT;
            WAIT:  if (bus.data_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               drain_cnt <= '0;
        else if (state == DRAIN)  drain_cnt <= drain_cnt + DW'(1);
        else                      drain_cnt <= '0;
    end

    // Planar walks col->row->cha, interleaved walks cha->col->row; carries ripple on wrap.
    always_comb begin
        row_nxt = row;
        col_nxt = col;
        cha_nxt = cha;
        if (!mode_q) begin
            col_nxt = col_wrap ? '0 : col + CW'(1);
            if (col_wrap) begin
                row_nxt = row_wrap ? '0 : row + RW'(1);
                if (row_wrap) cha_nxt = cha_wrap ? '0 : cha + KW'(1);
            end
        end else begin
            cha_nxt = cha_wrap ? '0 : cha + KW'(1);
            if (cha_wrap) begin
                col_nxt = col_wrap ? '0 : col + CW'(1);
                if (col_wrap) row_nxt = row_wrap ? '0 : row + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row    <= '0;
            col    <= '0;
            cha    <= '0;
            mode_q <= 1'b0;
        end else if (start_acc) begin
            row    <= '0;
            col    <= '0;
            cha    <= '0;
            mode_q <= bus.mode;
        end else if (enable_c) begin
            row <= row_nxt;
            col <= col_nxt;
            cha <= cha_nxt;
        end
    end

    // Free-running alignment line so *_dly lines up with RAM data regardless of stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: enable_c, addr: addr_c, row: row, col: col, cha: cha};
            for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign bus.enable_a  = enable_c;
    assign bus.addr      = addr_c;
    assign bus.busy      = (state == READ) || (state == DRAIN);
    assign bus.data_rdy  = (state == WAIT);
    assign bus.valid_dly = pipe[MEM_LAT-1].valid;
    assign bus.addr_dly  = pipe[MEM_LAT-1].addr;
    assign bus.row_dly   = pipe[MEM_LAT-1].row;
    assign bus.col_dly   = pipe[MEM_LAT-1].col;
    assign bus.cha_dly   = pipe[MEM_LAT-1].cha;

`ifdef IMG_READ_SEQ_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            frame_cycles <= '0;
        else if (start_acc)
            frame_cycles <= '0;
        else if (((state == READ) || (state == DRAIN)) && (frame_cycles != 16'hFFFF))
            frame_cycles <= frame_cycles + 16'd1;
    end
`endif
endmodule
